// File: rtl/md_scheduler_pkg.sv
// Shared encodings for the multiply/divide scheduler: EX-stage op codes, FSM states
// and small op-classification helpers.
package md_scheduler_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_md_class(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply / 32-bit divide datapath working on the latched operands.
// valid drops on divide-by-zero so the scheduler leaves HI/LO untouched.
module md_arith
    import md_scheduler_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
        a_neg  = (op == MD_DIV) && a[31];
        b_neg  = (op == MD_DIV) && b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        hi    = 32'd0;
        lo    = 32'd0;
        valid = 1'b0;
        case (op)
            MD_MULT: begin
                {hi, lo} = prod_s;
                valid    = 1'b1;
            end
            MD_MULTU: begin
                {hi, lo} = prod_u;
                valid    = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                lo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
                hi    = a_neg ? -r_mag : r_mag;
                valid = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// Multiply/divide sequencer beside the EX-stage ALU: fixed-latency FSM, HI/LO ownership
// and the decode stall for HI/LO-class instructions sitting in ID.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MdOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        MultTypeInstr_ID,
    output logic        Busy,
    output logic        Stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    md_op_t           op_reg, op_next;
    logic [31:0]      a_reg, a_next;
    logic [31:0]      b_reg, b_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;

    md_op_t      md_op;
    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        arith_valid;

    assign md_op = md_op_t'(MdOp);

    md_arith u_arith (
        .op    (op_reg),
        .a     (a_reg),
        .b     (b_reg),
        .hi    (arith_hi),
        .lo    (arith_lo),
        .valid (arith_valid)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (Start && is_md_class(md_op)) begin
                    op_next    = md_op;
                    a_next     = SrcA;
                    b_next     = SrcB;
                    count_next = is_mult(md_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    state_next = ST_BUSY;
                end else if (md_op == MD_MTHI) begin
                    hi_next = SrcA;
                end else if (md_op == MD_MTLO) begin
                    lo_next = SrcA;
                end
            end
            ST_BUSY: begin
                // Any Start/MTHI/MTLO seen here is dropped; completion always wins.
                if (count_reg == '0) begin
                    if (arith_valid) begin
                        hi_next = arith_hi;
                        lo_next = arith_lo;
                    end
                    state_next = ST_IDLE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            op_reg    <= MD_NONE;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign Busy     = (state_reg == ST_BUSY);
    assign Stall_MD = MultTypeInstr_ID & (Busy | (Start & is_md_class(md_op)));
    assign HI       = hi_reg;
    assign LO       = lo_reg;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed + random bench for md_scheduler; expected HI/LO come from plain 64-bit
// arithmetic on the operands, expected timing from the per-op cycle counts.
module tb_md_scheduler;
    import md_scheduler_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MdOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        MultTypeInstr_ID;
    logic        Busy;
    logic        Stall_MD;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .Start            (Start),
        .MdOp             (MdOp),
        .SrcA             (SrcA),
        .SrcB             (SrcB),
        .MultTypeInstr_ID (MultTypeInstr_ID),
        .Busy             (Busy),
        .Stall_MD         (Stall_MD),
        .HI               (HI),
        .LO               (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO after the op, computed with wide integer arithmetic.
    task automatic model_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MD_MULT: begin
                p = 64'(sa * sb);
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            MD_MULTU: begin
                p = 64'(a) * 64'(b);
                model_hi = p[63:32];
                model_lo = p[31:0];
            end
            MD_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                model_lo = q[31:0];
                model_hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                model_lo = a / b;
                model_hi = a % b;
            end
            MD_MTHI: model_hi = a;
            MD_MTLO: model_lo = a;
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge. MTHI junk is driven while busy to prove it is ignored.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic id_md);
        int n;
        n = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
        @(negedge clk);
        Start = 1'b1; MdOp = op; SrcA = a; SrcB = b; MultTypeInstr_ID = id_md;
        #1 check("stall_start", {63'd0, Stall_MD}, {63'd0, id_md});
        model_op(op, a, b);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MdOp = MD_MTHI;
        for (int k = 1; k <= n; k++) begin
            SrcA = $urandom; SrcB = $urandom;
            #1;
            check("busy_on", {63'd0, Busy}, 64'd1);
            check("stall_busy", {63'd0, Stall_MD}, {63'd0, id_md});
            @(posedge clk);
            @(negedge clk);
        end
        MdOp = MD_NONE;
        #1;
        check("busy_off", {63'd0, Busy}, 64'd0);
        check("stall_off", {63'd0, Stall_MD}, 64'd0);
        check("hi", {32'd0, HI}, {32'd0, model_hi});
        check("lo", {32'd0, LO}, {32'd0, model_lo});
        $display("op=%0d a=%h b=%h -> HI=%h LO=%h", op, a, b, HI, LO);
        MultTypeInstr_ID = 1'b0;
    endtask

    task automatic run_mt(input md_op_t op, input logic [31:0] a);
        @(negedge clk);
        Start = 1'b0; MdOp = op; SrcA = a; SrcB = $urandom;
        model_op(op, a, 32'd0);
        @(posedge clk);
        @(negedge clk);
        MdOp = MD_NONE;
        #1;
        check("mt_busy", {63'd0, Busy}, 64'd0);
        check("mt_hi", {32'd0, HI}, {32'd0, model_hi});
        check("mt_lo", {32'd0, LO}, {32'd0, model_lo});
        $display("mt op=%0d a=%h -> HI=%h LO=%h", op, a, HI, LO);
    endtask

    initial begin
        md_op_t      rop;
        logic [31:0] ra, rb;

        reset = 1'b0; Start = 1'b0; MdOp = MD_NONE; SrcA = '0; SrcB = '0;
        MultTypeInstr_ID = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        check("rst_stall", {63'd0, Stall_MD}, 64'd0);
        $display("reset: Busy=%b HI=%h LO=%h", Busy, HI, LO);
        reset = 1'b1;

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("t1_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        check("t1_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFEB);
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0);
        check("t2_lo_const", {32'd0, LO}, 64'd14);
        check("t2_hi_const", {32'd0, HI}, 64'd2);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("t2b_lo_const", {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
        check("t2b_hi_const", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_mt(MD_MTHI, 32'h1234_5678);
        run_mt(MD_MTHI, 32'd5);
        run_mt(MD_MTLO, 32'd9);
        run_op(MD_DIV, 32'd1234, 32'd0, 1'b1);
        check("t5_hi_const", {32'd0, HI}, 64'd5);
        check("t5_lo_const", {32'd0, LO}, 64'd9);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Abort a divide three cycles in.
        @(negedge clk);
        Start = 1'b1; MdOp = MD_DIV; SrcA = 32'd77; SrcB = 32'd3; MultTypeInstr_ID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MdOp = MD_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_hi", {32'd0, HI}, 64'd0);
        check("abort_lo", {32'd0, LO}, 64'd0);
        check("abort_stall", {63'd0, Stall_MD}, 64'd0);
        $display("abort: Busy=%b HI=%h LO=%h Stall_MD=%b", Busy, HI, LO, Stall_MD);
        model_hi = 32'd0;
        model_lo = 32'd0;
        MultTypeInstr_ID = 1'b0;

        for (int i = 0; i < 24; i++) begin
            rop = md_op_t'(3'($urandom_range(1, 6)));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (rop == MD_MTHI || rop == MD_MTLO) run_mt(rop, ra);
            else run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
